// File: rtl/logic_unit_pipe_if.sv
// Command/result bundle for logic_unit_pipe.
// The slave modport is the unit; the master modport is the command source and result sink.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_en;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             ones;
    logic             parity;
    logic             op_err;

    modport master (
        output in_valid, a, b, op, acc_en, acc_clr, out_ready,
        input  in_ready, out_valid, out, zero, ones, parity, op_err
    );

    modport slave (
        input  in_valid, a, b, op, acc_en, acc_clr, out_ready,
        output in_ready, out_valid, out, zero, ones, parity, op_err
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Single-stage registered bitwise logic unit with valid/ready handshake,
// result status flags and an accumulator that can stand in for operand B.
module logic_unit_pipe #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    logic_unit_pipe_if.slave bus
);
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             res_err;
    logic             accept;
    logic             xfer;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             vld_q, vld_d;
    logic             zero_q, zero_d;
    logic             ones_q, ones_d;
    logic             par_q, par_d;
    logic             err_q, err_d;

    assign bus.in_ready = !vld_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign xfer         = vld_q && bus.out_ready;

    always_comb begin
        opb     = bus.acc_en ? acc_q : bus.b;
        res     = '0;
        res_err = 1'b0;
        case (bus.op)
            3'd0:    res = bus.a & opb;
            3'd1:    res = bus.a | opb;
            3'd2:    res = ~bus.a;
            3'd3:    res = ~(bus.a & opb);
            3'd4:    res = ~(bus.a | opb);
            3'd5:    res = bus.a ^ opb;
            3'd6:    res = ~(bus.a ^ opb);
            default: res_err = 1'b1;
        endcase
    end

    // Flags are captured with the result so they always describe out_q.
    always_comb begin
        out_d  = out_q;
        vld_d  = vld_q;
        zero_d = zero_q;
        ones_d = ones_q;
        par_d  = par_q;
        err_d  = err_q;
        acc_d  = acc_q;
        if (accept) begin
            out_d  = res;
            vld_d  = 1'b1;
            zero_d = (res == '0);
            ones_d = (res == '1);
            par_d  = ^res;
            err_d  = res_err;
            acc_d  = res;
        end else if (xfer) begin
            vld_d = 1'b0;
        end
        if (bus.acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q  <= '0;
            acc_q  <= '0;
            vld_q  <= 1'b0;
            zero_q <= 1'b1;
            ones_q <= 1'b0;
            par_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            acc_q  <= acc_d;
            vld_q  <= vld_d;
            zero_q <= zero_d;
            ones_q <= ones_d;
            par_q  <= par_d;
            err_q  <= err_d;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.out       = out_q;
    assign bus.zero      = zero_q;
    assign bus.ones      = ones_q;
    assign bus.parity    = par_q;
    assign bus.op_err    = err_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe at WIDTH=8 and WIDTH=1.
// Expected results come from a behavioural model of the operations and handshake.
module tb_logic_unit_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(8)) bus ();
    logic_unit_pipe_if #(.WIDTH(1)) bus1 ();

    logic_unit_pipe #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus));
    logic_unit_pipe #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct packed {
        logic [7:0] o;
        logic       z;
        logic       on;
        logic       p;
        logic       e;
    } exp_t;

    exp_t       q8[$];
    exp_t       q1[$];
    int         nvec = 0;
    int         nerr = 0;
    logic [7:0] macc = 8'h00;
    logic       mvld = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(logic [2:0] op, logic [7:0] a,
                                   logic [7:0] b, logic [7:0] mask);
        exp_t       e;
        logic [7:0] r;
        e.e = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = ~a;
            3'd3: r = ~(a & b);
            3'd4: r = ~(a | b);
            3'd5: r = a ^ b;
            3'd6: r = ~(a ^ b);
            default: begin
                r   = 8'h00;
                e.e = 1'b1;
            end
        endcase
        r    = r & mask;
        e.o  = r;
        e.z  = (r == 8'h00);
        e.on = (r == mask);
        e.p  = ^r;
        return e;
    endfunction

    // One clock of the 8-bit unit: predict handshake, record accepted requests.
    task automatic tick8();
        exp_t e;
        logic rdy_m;
        logic acc;
        e = '0;
        @(negedge clk);
        rdy_m = !mvld || bus.out_ready;
        chk("in_ready", {31'b0, bus.in_ready}, {31'b0, rdy_m});
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, mvld});
        if (!rst_n) begin
            q8.delete();
            mvld = 1'b0;
            macc = 8'h00;
        end else begin
            acc = bus.in_valid && rdy_m;
            if (acc) begin
                e = model(bus.op, bus.a, bus.acc_en ? macc : bus.b, 8'hFF);
                q8.push_back(e);
            end
            if (bus.acc_clr) macc = 8'h00;
            else if (acc) macc = e.o;
            if (acc) mvld = 1'b1;
            else if (mvld && bus.out_ready) mvld = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic v, logic [7:0] a, logic [7:0] b,
                        logic [2:0] op, logic en, logic clr);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.op       = op;
        bus.acc_en   = en;
        bus.acc_clr  = clr;
        tick8();
    endtask

    task automatic tick1();
        @(negedge clk);
        chk("in_ready1", {31'b0, bus1.in_ready}, 32'd1);
        if (bus1.in_valid)
            q1.push_back(model(bus1.op, {7'b0, bus1.a}, {7'b0, bus1.b}, 8'h01));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (q8.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL out8: unexpected result %0h", bus.out);
            end else begin
                chk("out8", {20'b0, bus.out, bus.zero, bus.ones, bus.parity, bus.op_err},
                    {20'b0, q8[0]});
                if (bus.out_ready) void'(q8.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus1.out_valid) begin
            if (q1.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL out1: unexpected result %0h", bus1.out);
            end else begin
                chk("out1", {20'b0, 7'b0, bus1.out, bus1.zero, bus1.ones,
                             bus1.parity, bus1.op_err}, {20'b0, q1[0]});
                if (bus1.out_ready) void'(q1.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.op        = 3'd0;
        bus.acc_en    = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.a         = 1'b0;
        bus1.b         = 1'b0;
        bus1.op        = 3'd0;
        bus1.acc_en    = 1'b0;
        bus1.acc_clr   = 1'b0;
        bus1.out_ready = 1'b1;

        rst_n = 1'b0;
        tick8();
        tick8();
        rst_n = 1'b1;
        chk("rst out", {24'b0, bus.out}, 32'h0);
        chk("rst zero", {31'b0, bus.zero}, 32'd1);
        chk("rst ones", {31'b0, bus.ones}, 32'd0);
        chk("rst parity", {31'b0, bus.parity}, 32'd0);
        chk("rst op_err", {31'b0, bus.op_err}, 32'd0);

        // back-to-back stream
        send(1, 8'hF0, 8'hCC, 3'd0, 0, 0);
        send(1, 8'hF0, 8'hCC, 3'd1, 0, 0);
        send(1, 8'hF0, 8'hCC, 3'd5, 0, 0);
        send(1, 8'hF0, 8'hCC, 3'd6, 0, 0);
        send(0, 8'h00, 8'h00, 3'd0, 0, 0);

        // backpressure
        send(1, 8'hFF, 8'h0F, 3'd4, 0, 0);
        bus.out_ready = 1'b0;
        send(1, 8'h55, 8'h33, 3'd0, 0, 0);
        tick8();
        tick8();
        bus.out_ready = 1'b1;
        tick8();
        send(0, 8'h00, 8'h00, 3'd0, 0, 0);

        // accumulate chain, clear collision, NOT
        send(0, 8'h00, 8'h00, 3'd0, 0, 1);
        send(1, 8'h01, 8'hAA, 3'd1, 1, 0);
        send(1, 8'h02, 8'hAA, 3'd1, 1, 0);
        send(1, 8'h04, 8'hAA, 3'd1, 1, 0);
        send(1, 8'h01, 8'hAA, 3'd5, 1, 1);
        send(1, 8'h10, 8'hAA, 3'd1, 1, 0);
        send(1, 8'h0F, 8'hAA, 3'd2, 1, 0);
        send(1, 8'h3C, 8'h00, 3'd7, 0, 0);
        send(0, 8'h00, 8'h00, 3'd0, 0, 0);

        // reset during a stall
        send(1, 8'hAA, 8'h55, 3'd5, 0, 0);
        bus.out_ready = 1'b0;
        send(0, 8'h00, 8'h00, 3'd0, 0, 0);
        rst_n = 1'b0;
        tick8();
        rst_n = 1'b1;
        chk("rst2 out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst2 out", {24'b0, bus.out}, 32'h0);
        chk("rst2 zero", {31'b0, bus.zero}, 32'd1);
        chk("rst2 in_ready", {31'b0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        send(1, 8'h00, 8'hFF, 3'd1, 1, 0);
        send(0, 8'h00, 8'h00, 3'd0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            send(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0));
        end
        bus.out_ready = 1'b1;
        send(0, 8'h00, 8'h00, 3'd0, 0, 0);
        tick8();
        tick8();
        chk("q8 drained", q8.size(), 32'd0);

        // exhaustive 1-bit truth table
        for (int x = 0; x < 2; x++) begin
            for (int y = 0; y < 2; y++) begin
                for (int o = 0; o < 8; o++) begin
                    bus1.in_valid = 1'b1;
                    bus1.a        = x[0];
                    bus1.b        = y[0];
                    bus1.op       = o[2:0];
                    tick1();
                end
            end
        end
        bus1.in_valid = 1'b0;
        tick1();
        tick1();
        chk("q1 drained", q1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
